// File: rtl/idma_reg64_launcher.sv
// Register-bus initiator that programs the 64-bit iDMA reg frontend for one job at a time.
// Optional IDMA_LAUNCHER_IRQ_WAIT_EN: wait for irq_i between DONE polls instead of a fixed gap.
module idma_reg64_launcher #(
    parameter int unsigned AddrWidth    = 64,
    parameter int unsigned PollInterval = 16,
    parameter int unsigned TimeoutPolls = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 job_valid_i,
    output logic                 job_ready_o,
    input  logic [AddrWidth-1:0] job_src_i,
    input  logic [AddrWidth-1:0] job_dst_i,
    input  logic [AddrWidth-1:0] job_len_i,
    input  logic [2:0]           job_conf_i,
    output logic [5:0]           reg_req_addr_o,
    output logic                 reg_req_write_o,
    output logic [63:0]          reg_req_wdata_o,
    output logic [7:0]           reg_req_wstrb_o,
    output logic                 reg_req_valid_o,
    input  logic [63:0]          reg_rsp_rdata_i,
    input  logic                 reg_rsp_error_i,
    input  logic                 reg_rsp_ready_i,
    input  logic                 irq_i,
    output logic                 cmpl_valid_o,
    input  logic                 cmpl_ready_i,
    output logic [63:0]          cmpl_id_o,
    output logic [1:0]           cmpl_status_o
);
    typedef enum logic [3:0] {
        S_IDLE, S_WR_SRC, S_WR_DST, S_WR_LEN, S_WR_CONF, S_RD_NID, S_GAP, S_RD_DONE, S_CMPL
    } state_e;

    localparam logic [31:0] TIMEOUT = 32'(TimeoutPolls);

    state_e      state_q, state_d;
    logic [63:0] src_q, dst_q, len_q, id_q, id_d, done_diff;
    logic [2:0]  conf_q;
    logic [1:0]  status_q, status_d;
    logic [31:0] poll_q, poll_d;
    logic        retired;

`ifndef IDMA_LAUNCHER_IRQ_WAIT_EN
    logic [31:0] gap_q, gap_d;
    logic        unused_irq;
    assign unused_irq = irq_i;
`endif

    assign job_ready_o   = (state_q == S_IDLE) && !rst_i;
    assign cmpl_id_o     = id_q;
    assign cmpl_status_o = status_q;

    // Wrap-safe retirement: DONE has caught up with our ID modulo 2^64.
    assign done_diff = reg_rsp_rdata_i - id_q;
    assign retired   = !done_diff[63];

    always_comb begin
        state_d         = state_q;
        id_d            = id_q;
        status_d        = status_q;
        poll_d          = poll_q;
`ifndef IDMA_LAUNCHER_IRQ_WAIT_EN
        gap_d           = gap_q;
`endif
        reg_req_valid_o = 1'b0;
        reg_req_write_o = 1'b0;
        reg_req_addr_o  = 6'h00;
        reg_req_wdata_o = 64'h0;
        reg_req_wstrb_o = 8'h00;
        cmpl_valid_o    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (job_valid_i && job_ready_o) begin
                    id_d   = 64'h0;
                    poll_d = 32'h0;
                    if (job_len_i == '0) begin
                        status_d = 2'd1;
                        state_d  = S_CMPL;
                    end else begin
                        status_d = 2'd0;
                        state_d  = S_WR_SRC;
                    end
                end
            end
            S_WR_SRC, S_WR_DST, S_WR_LEN, S_WR_CONF: begin
                reg_req_valid_o = 1'b1;
                reg_req_write_o = 1'b1;
                reg_req_wstrb_o = 8'hFF;
                case (state_q)
                    S_WR_SRC: begin reg_req_addr_o = 6'h00; reg_req_wdata_o = src_q; end
                    S_WR_DST: begin reg_req_addr_o = 6'h08; reg_req_wdata_o = dst_q; end
                    S_WR_LEN: begin reg_req_addr_o = 6'h10; reg_req_wdata_o = len_q; end
                    default:  begin reg_req_addr_o = 6'h18; reg_req_wdata_o = {61'b0, conf_q}; end
                endcase
                if (reg_rsp_ready_i)
                    state_d = state_e'(state_q + 4'd1);
            end
            S_RD_NID: begin
                reg_req_valid_o = 1'b1;
                reg_req_addr_o  = 6'h28;
                if (reg_rsp_ready_i) begin
                    id_d    = reg_rsp_rdata_i;
                    state_d = S_GAP;
`ifndef IDMA_LAUNCHER_IRQ_WAIT_EN
                    gap_d   = 32'h0;
`endif
                end
            end
            S_GAP: begin
`ifdef IDMA_LAUNCHER_IRQ_WAIT_EN
                if (irq_i) begin
                    state_d = S_RD_DONE;
                end else if (TimeoutPolls != 0 && poll_q + 32'd1 >= TIMEOUT) begin
                    status_d = 2'd3;
                    state_d  = S_CMPL;
                end else begin
                    poll_d = poll_q + 32'd1;
                end
`else
                if (gap_q == 32'(PollInterval - 1)) state_d = S_RD_DONE;
                else                                 gap_d   = gap_q + 32'd1;
`endif
            end
            S_RD_DONE: begin
                reg_req_valid_o = 1'b1;
                reg_req_addr_o  = 6'h30;
                if (reg_rsp_ready_i) begin
                    if (retired) begin
                        status_d = 2'd0;
                        state_d  = S_CMPL;
                    end else begin
`ifdef IDMA_LAUNCHER_IRQ_WAIT_EN
                        state_d = S_GAP;
`else
                        gap_d = 32'h0;
                        if (TimeoutPolls != 0 && poll_q + 32'd1 == TIMEOUT) begin
                            status_d = 2'd3;
                            state_d  = S_CMPL;
                        end else begin
                            poll_d  = poll_q + 32'd1;
                            state_d = S_GAP;
                        end
`endif
                    end
                end
            end
            S_CMPL: begin
                cmpl_valid_o = 1'b1;
                if (cmpl_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A bus error in any access aborts; the ID is whatever was latched before it.
        if (reg_req_valid_o && reg_rsp_ready_i && reg_rsp_error_i) begin
            id_d     = id_q;
            status_d = 2'd2;
            state_d  = S_CMPL;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            src_q    <= 64'h0;
            dst_q    <= 64'h0;
            len_q    <= 64'h0;
            conf_q   <= 3'h0;
            id_q     <= 64'h0;
            status_q <= 2'd0;
            poll_q   <= 32'h0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            status_q <= status_d;
            poll_q   <= poll_d;
            if (job_valid_i && job_ready_o) begin
                src_q  <= 64'(job_src_i);
                dst_q  <= 64'(job_dst_i);
                len_q  <= 64'(job_len_i);
                conf_q <= job_conf_i;
            end
        end
    end

`ifndef IDMA_LAUNCHER_IRQ_WAIT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) gap_q <= 32'h0;
        else       gap_q <= gap_d;
    end
`endif

endmodule

// File: tb/tb_idma_reg64_launcher.sv
// Randomized bench for idma_reg64_launcher: scripted reg responder plus a job-level reference model.
module tb_idma_reg64_launcher;
    localparam int PI = 16;
    localparam int TO = 4;

    typedef struct {
        logic [5:0]  addr;
        logic        we;
        logic [63:0] wdata;
        int          st;
        int          en;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_valid_i = 1'b0, job_ready_o;
    logic [63:0] job_src_i = '0, job_dst_i = '0, job_len_i = '0;
    logic [2:0]  job_conf_i = '0;
    logic [5:0]  reg_req_addr_o;
    logic        reg_req_write_o, reg_req_valid_o;
    logic [63:0] reg_req_wdata_o;
    logic [7:0]  reg_req_wstrb_o;
    logic [63:0] reg_rsp_rdata_i = '0;
    logic        reg_rsp_error_i = 1'b0, reg_rsp_ready_i = 1'b0;
    logic        irq_i = 1'b0;
    logic        cmpl_valid_o, cmpl_ready_i = 1'b0;
    logic [63:0] cmpl_id_o;
    logic [1:0]  cmpl_status_o;

    always #5 clk = ~clk;

    idma_reg64_launcher #(.AddrWidth(64), .PollInterval(PI), .TimeoutPolls(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
        .job_src_i(job_src_i), .job_dst_i(job_dst_i), .job_len_i(job_len_i), .job_conf_i(job_conf_i),
        .reg_req_addr_o(reg_req_addr_o), .reg_req_write_o(reg_req_write_o),
        .reg_req_wdata_o(reg_req_wdata_o), .reg_req_wstrb_o(reg_req_wstrb_o),
        .reg_req_valid_o(reg_req_valid_o), .reg_rsp_rdata_i(reg_rsp_rdata_i),
        .reg_rsp_error_i(reg_rsp_error_i), .reg_rsp_ready_i(reg_rsp_ready_i),
        .irq_i(irq_i), .cmpl_valid_o(cmpl_valid_o), .cmpl_ready_i(cmpl_ready_i),
        .cmpl_id_o(cmpl_id_o), .cmpl_status_o(cmpl_status_o)
    );

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // responder script
    int          dly_min = 0, dly_max = 0, err_at = -1, acc_n = 0, di = 0;
    logic [63:0] nid = '0, stuck = '0;
    logic [63:0] done_script[$];
    acc_t        log_q[$];
    acc_t        exp_q[$];

    initial begin
        logic pend;
        int   wt;
        acc_t cur;
        pend = 1'b0;
        wt   = 0;
        forever begin
            @(negedge clk);
            reg_rsp_ready_i = 1'b0;
            reg_rsp_error_i = 1'b0;
            reg_rsp_rdata_i = '0;
            if (rst || !reg_req_valid_o) begin
                pend = 1'b0;
                continue;
            end
            if (!pend) begin
                pend      = 1'b1;
                wt        = $urandom_range(dly_max, dly_min);
                cur.addr  = reg_req_addr_o;
                cur.we    = reg_req_write_o;
                cur.wdata = reg_req_wdata_o;
                cur.st    = cyc;
                chk("wstrb", 64'(reg_req_wstrb_o), reg_req_write_o ? 64'hFF : 64'h0);
            end else begin
                chk("hold_addr", 64'(reg_req_addr_o), 64'(cur.addr));
                chk("hold_we", 64'(reg_req_write_o), 64'(cur.we));
                chk("hold_wdata", reg_req_wdata_o, cur.wdata);
            end
            if (wt == 0) begin
                reg_rsp_ready_i = 1'b1;
                pend   = 1'b0;
                cur.en = cyc + 1;
                if (!cur.we && cur.addr == 6'h28) reg_rsp_rdata_i = nid;
                else if (!cur.we && cur.addr == 6'h30) begin
                    reg_rsp_rdata_i = (di < done_script.size()) ? done_script[di] : stuck;
                    di++;
                end
                if (acc_n == err_at) reg_rsp_error_i = 1'b1;
                acc_n++;
                log_q.push_back(cur);
            end else begin
                wt--;
            end
        end
    end

    // Reference: list of accesses the job should produce, and its completion record.
    task automatic model_job(input logic [63:0] src, input logic [63:0] dst, input logic [63:0] len,
                             input logic [2:0] conf, output logic [63:0] eid, output logic [1:0] est);
        acc_t        e;
        logic [63:0] v, id;
        int          n, polls;
        exp_q.delete();
        e.st = 0;
        e.en = 0;
        eid  = '0;
        if (len == 0) begin est = 2'd1; return; end
        for (int k = 0; k < 5; k++) begin
            e.addr  = (k == 4) ? 6'h28 : 6'(k * 8);
            e.we    = (k < 4);
            e.wdata = (k == 0) ? src : (k == 1) ? dst : (k == 2) ? len : (k == 3) ? {61'b0, conf} : 64'h0;
            exp_q.push_back(e);
            if (err_at == k) begin est = 2'd2; return; end
        end
        id    = nid;
        n     = 5;
        polls = 0;
        forever begin
            e.addr  = 6'h30;
            e.we    = 1'b0;
            e.wdata = '0;
            exp_q.push_back(e);
            v = (n - 5 < done_script.size()) ? done_script[n - 5] : stuck;
            if (err_at == n) begin eid = id; est = 2'd2; return; end
            n++;
            if ($signed(v - id) >= 0) begin eid = id; est = 2'd0; return; end
            polls++;
            if (polls == TO) begin eid = id; est = 2'd3; return; end
        end
    endtask

    task automatic run_job(input string nm, input logic [63:0] src, input logic [63:0] dst,
                           input logic [63:0] len, input logic [2:0] conf);
        logic [63:0] eid;
        logic [1:0]  est;
        int          t, gap;
        model_job(src, dst, len, conf, eid, est);
        di = 0;
        acc_n = 0;
        log_q.delete();
        t = 0;
        while (!job_ready_o && t < 100) begin @(negedge clk); t++; end
        chk({nm, ":job_ready"}, 64'(job_ready_o), 64'd1);
        job_valid_i = 1'b1;
        job_src_i = src; job_dst_i = dst; job_len_i = len; job_conf_i = conf;
        @(negedge clk);
        job_valid_i = 1'b0;
        if (len == 0) chk({nm, ":zero_lat"}, 64'(cmpl_valid_o), 64'd1);
        t = 0;
        while (!cmpl_valid_o && t < 3000) begin @(negedge clk); t++; end
        chk({nm, ":cmpl_seen"}, 64'(cmpl_valid_o), 64'd1);
        chk({nm, ":id"}, cmpl_id_o, eid);
        chk({nm, ":status"}, 64'(cmpl_status_o), 64'(est));
        chk({nm, ":busy_ready"}, 64'(job_ready_o), 64'd0);
        chk({nm, ":n_acc"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            chk({nm, ":addr"}, 64'(log_q[i].addr), 64'(exp_q[i].addr));
            chk({nm, ":we"}, 64'(log_q[i].we), 64'(exp_q[i].we));
            chk({nm, ":wdata"}, log_q[i].wdata, exp_q[i].wdata);
            if (i > 0) begin
                gap = (log_q[i].addr == 6'h30) ? PI : 0;
                chk({nm, ":gap"}, 64'(log_q[i].st - log_q[i-1].en), 64'(gap));
            end
        end
        t = $urandom_range(2);
        repeat (t) begin
            @(negedge clk);
            chk({nm, ":cmpl_hold"}, 64'(cmpl_valid_o), 64'd1);
            chk({nm, ":id_hold"}, cmpl_id_o, eid);
        end
        cmpl_ready_i = 1'b1;
        @(negedge clk);
        cmpl_ready_i = 1'b0;
        chk({nm, ":cmpl_drop"}, 64'(cmpl_valid_o), 64'd0);
        chk({nm, ":idle_ready"}, 64'(job_ready_o), 64'd1);
    endtask

    initial begin
        int          t, nn;
        logic [63:0] r;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(reg_req_valid_o), 64'd0);
        chk("rst_job_ready", 64'(job_ready_o), 64'd0);
        chk("rst_cmpl", 64'(cmpl_valid_o), 64'd0);
        chk("rst_addr", 64'(reg_req_addr_o), 64'd0);
        chk("rst_wdata", reg_req_wdata_o, 64'd0);
        chk("rst_wstrb", 64'(reg_req_wstrb_o), 64'd0);
        chk("rst_id", cmpl_id_o, 64'd0);
        chk("rst_status", 64'(cmpl_status_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        nid = 64'd5; stuck = 64'd5; done_script = '{64'd4, 64'd4, 64'd5};
        run_job("basic", 64'h1000, 64'h2000, 64'h40, 3'd0);
        run_job("zero", 64'h1234, 64'h5678, 64'h0, 3'd5);
        dly_min = 3; dly_max = 3;
        run_job("stall", 64'h1000, 64'h2000, 64'h40, 3'd0);
        dly_min = 0; dly_max = 0;
        err_at = 1;
        run_job("err_dst", 64'h1000, 64'h2000, 64'h40, 3'd1);
        err_at = 6;
        run_job("err_done", 64'h1000, 64'h2000, 64'h40, 3'd2);
        err_at = -1;
        nid = 64'hFFFF_FFFF_FFFF_FFFF; done_script = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h0};
        run_job("wrap", 64'hA, 64'hB, 64'h8, 3'd7);
        nid = 64'd5; stuck = 64'd0; done_script = '{};
        run_job("timeout", 64'hC, 64'hD, 64'h10, 3'd3);

        // Reset while a write to NUM_BYTES is stalled.
        dly_min = 3; dly_max = 3;
        t = 0;
        while (!job_ready_o && t < 100) begin @(negedge clk); t++; end
        job_valid_i = 1'b1; job_len_i = 64'h40;
        @(negedge clk);
        job_valid_i = 1'b0;
        t = 0;
        while (!(reg_req_valid_o && reg_req_addr_o == 6'h10) && t < 200) begin @(negedge clk); t++; end
        chk("rst_reach_len", 64'(reg_req_valid_o && reg_req_addr_o == 6'h10), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 64'(reg_req_valid_o), 64'd0);
        chk("midrst_job_ready", 64'(job_ready_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_job_ready", 64'(job_ready_o), 64'd1);
        chk("postrst_valid", 64'(reg_req_valid_o), 64'd0);
        dly_min = 0; dly_max = 1;
        nid = 64'd7; stuck = 64'd7; done_script = '{64'd7};
        run_job("rst_recover", 64'h3000, 64'h4000, 64'h80, 3'd4);

        for (int j = 0; j < 25; j++) begin
            dly_min = 0;
            dly_max = $urandom_range(2);
            err_at  = ($urandom_range(4) == 0) ? int'($urandom_range(7)) : -1;
            nid     = ($urandom_range(3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(2))
                                               : {$urandom, $urandom};
            stuck   = nid - 64'd1;
            done_script.delete();
            nn = $urandom_range(4);
            for (int k = 0; k < nn; k++) done_script.push_back(nid - 64'($urandom_range(1000, 1)));
            done_script.push_back(nid + 64'($urandom_range(3)));
            r = ($urandom_range(4) == 0) ? 64'h0 : {$urandom, $urandom};
            run_job("rand", {$urandom, $urandom}, {$urandom, $urandom}, r, 3'($urandom_range(7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
